// File: rtl/eth_crc_pkg.sv
// Shared constants and types for the streaming Ethernet CRC-32 engine.
// Latency: n/a (constants, types and a constant helper function only).
// Backpressure: n/a.
package eth_crc_pkg;

    localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
    // Complemented register value left after a frame that includes a good FCS.
    localparam logic [31:0] CRC32_RESIDUE_OUT = 32'h2144DF1C;

    typedef enum logic {
        ST_ACC,
        ST_RES
    } state_t;

    // Bit-reverse a 32-bit word. The reflected LFSR shifts toward bit 0,
    // so it needs the polynomial in reversed bit order.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

endpackage

// File: rtl/eth_crc32_byte_step.sv
// Folds one byte into a reflected CRC-32 register (bit 0 of the byte first).
// Latency: purely combinational, no cycles.
// Backpressure: none; this is a pure function of its inputs.
// Ports: crc_in (register before the byte), data (byte), crc_out (register after).
module eth_crc32_byte_step
    import eth_crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_mac_crc32_stream.sv
// Multi-byte-per-beat IEEE 802.3 CRC-32 engine with a per-frame result port.
// Latency: res_valid rises the cycle after the s_last beat transfers.
// Backpressure: s_ready drops while a result is held; one frame per beats+1 cycles.
// Ports: s_* input beat stream (valid/ready, data, keep, last); crc_clear aborts
//        the frame in progress; res_* result handshake with FCS, FCS-check
//        verdict and a sticky byte-enable protocol error flag.
module eth_mac_crc32_stream
    import eth_crc_pkg::*;
#(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] INIT       = CRC32_INIT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    input  logic                    crc_clear,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_crc,
    output logic                    res_ok,
    output logic                    res_keep_err
);

    state_t                state_q, state_d;
    logic [31:0]           crc_q;
    logic                  keep_err_q;
    logic [31:0]           res_crc_q;
    logic                  res_keep_err_q;
    logic                  ready_en_q;
    logic [DATA_BYTES-1:0] keep_eff;
    logic [31:0]           crc_next;
    logic                  viol;
    logic                  xfer;

    // Only the run of ones starting at bit 0 is honoured; anything above the
    // first zero is ignored and flagged as a violation.
    always_comb begin
        keep_eff    = '0;
        keep_eff[0] = s_keep[0];
        for (int i = 1; i < DATA_BYTES; i++) begin
            keep_eff[i] = keep_eff[i-1] & s_keep[i];
        end
    end

    assign viol = (keep_eff != s_keep) || (!s_last && (keep_eff != {DATA_BYTES{1'b1}}));

    // Byte-serial chain: each stage either folds its byte or passes through.
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_step
        logic [31:0] c_in;
        logic [31:0] stepped;
        logic [31:0] c_out;

        if (i == 0) begin : g_first
            assign c_in = crc_q;
        end else begin : g_next
            assign c_in = g_step[i-1].c_out;
        end

        eth_crc32_byte_step u_step (
            .crc_in  (c_in),
            .data    (s_data[8*i +: 8]),
            .crc_out (stepped)
        );

        assign c_out = keep_eff[i] ? stepped : c_in;
    end

    assign crc_next = g_step[DATA_BYTES-1].c_out;

    // ready_en_q holds s_ready low through reset and for the first cycle after.
    assign s_ready      = ready_en_q && (state_q == ST_ACC);
    // A beat presented alongside crc_clear is dropped.
    assign xfer         = s_valid && s_ready && !crc_clear;
    assign res_valid    = (state_q == ST_RES);
    assign res_crc      = res_crc_q;
    assign res_keep_err = res_keep_err_q;
    assign res_ok       = (res_crc_q == CRC32_RESIDUE_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: if (xfer && s_last) state_d = ST_RES;
            ST_RES: if (res_ready)      state_d = ST_ACC;
            default:                    state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q          <= INIT;
            keep_err_q     <= 1'b0;
            res_crc_q      <= 32'h0;
            res_keep_err_q <= 1'b0;
            ready_en_q     <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (state_q == ST_ACC) begin
                if (crc_clear) begin
                    crc_q      <= INIT;
                    keep_err_q <= 1'b0;
                end else if (xfer) begin
                    if (s_last) begin
                        res_crc_q      <= ~crc_next;
                        res_keep_err_q <= keep_err_q | viol;
                        crc_q          <= INIT;
                        keep_err_q     <= 1'b0;
                    end else begin
                        crc_q      <= crc_next;
                        keep_err_q <= keep_err_q | viol;
                    end
                end
            end
        end
    end

endmodule

// File: doc/eth_mac_crc32_stream.md
Name: eth_mac_crc32_stream

Overview:
Parametrised, multi-byte-per-cycle IEEE 802.3 CRC-32 engine with a valid/ready stream interface.
- Accumulates CRC over DATA_BYTES bytes per beat, with partial last beats.
- Delivers a per-frame result: FCS value, plus an FCS-check verdict when the frame includes its FCS.
- Sits beside the MAC TX/RX datapaths at wider internal bus widths, where the byte-serial CRC no longer meets throughput.

Parameters:
DATA_BYTES, 4, bytes per input beat (1..16).
INIT, 32'hFFFFFFFF, CRC register value at frame start.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_valid  input  1  input beat valid
s_ready  output  1  engine can accept beat
s_data  input  8*DATA_BYTES  beat data; byte 0 = s_data[7:0] = first byte on wire
s_keep  input  DATA_BYTES  byte enables; must be contiguous from bit 0
s_last  input  1  final beat of frame
crc_clear  input  1  synchronous abort; discards the frame in progress
res_valid  output  1  frame result valid
res_ready  input  1  result consumer ready
res_crc  output  32  FCS value = bitwise complement of the final register
res_ok  output  1  1 when the frame (FCS included) leaves residue res_crc == 32'h2144DF1C
res_keep_err  output  1  a protocol violation occurred in this frame

Behaviour:
- CRC definition: reflected CRC-32, polynomial 0x04C11DB7, bit 0 of each byte processed first, register init INIT, output complemented. "123456789" -> 32'hCBF43926.
- Beat transfer: occurs when s_valid && s_ready. Enabled bytes are folded into the register in ascending byte order in one cycle. Disabled bytes have no effect.
- s_keep == 0 is legal only with s_last: it finalises the frame with no additional data.
- Protocol violations: non-contiguous s_keep, or s_keep not all ones on a non-last beat.
  - res_keep_err is set for the frame (sticky until the result is accepted).
  - Bytes are still processed using only the lowest contiguous run of ones.
- State machine, two states:
  - ACC: s_ready = 1.
    - A transfer with s_last moves to RES and loads res_* from the post-beat register (one-cycle latency: res_valid rises the cycle after the last beat).
    - The register reloads INIT in the same edge.
  - RES: s_ready = 0 and res_* are held stable.
    - res_valid && res_ready returns to ACC.
    - The next frame's first beat can transfer in the cycle after acceptance (max throughput: one frame per beats+1 cycles).
- crc_clear:
  - In ACC: the register reloads INIT, keep_err clears, and any same-cycle beat is dropped. s_ready stays 1.
  - In RES: no effect on the held result.
- Reset: state = ACC, register = INIT. Outputs: s_ready = 1 one cycle after reset release (0 during reset), res_valid = 0, res_crc = 0, res_ok = 0, res_keep_err = 0. Reset mid-frame discards all partial state.
- res_ok is combinational on the held register and is only meaningful while res_valid = 1.
- Single-beat frames (s_last on the first beat) are legal. Back-to-back frames carry no state between them.

Decomposition:
- Package eth_crc_pkg holds:
  - CRC32_POLY = 32'h04C11DB7
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_RESIDUE_OUT = 32'h2144DF1C
  - the state enum {ST_ACC, ST_RES}
- Sub-module eth_crc32_byte_step: combinational single-byte update (reflected LFSR unrolled over 8 bits).
  - The top instantiates DATA_BYTES copies in a generate chain.
  - Each stage's output is muxed by its keep bit (bypass when 0).
- The top holds the FSM, the CRC register, the result registers and keep validation.

Test Plan:
- DATA_BYTES=4, beats "1234","5678","9" (keep 1111,1111,0001, last on beat 3) -> res_valid the next cycle; res_crc = 32'hCBF43926, res_ok = 0, res_keep_err = 0.
- Same nine bytes followed by FCS bytes 26 39 F4 CB (beats keep 1111,1111,1111,0001) -> res_ok = 1.
- Hold res_ready = 0 for 5 cycles after a frame -> s_ready = 0 throughout; res_crc stable. Back-to-back second frame starts the cycle after acceptance and yields the correct independent CRC.
- Assert crc_clear after beat 1 of a frame, then send "123456789" -> 32'hCBF43926. A beat presented together with crc_clear has no effect.
- Non-last beat with keep 1011 -> res_keep_err = 1 for that frame. The next clean frame has res_keep_err = 0.
- Assert rst_n low mid-frame -> res_valid = 0 and res_crc = 0 immediately; the following full frame is correct. Repeat the first case with DATA_BYTES=1 and DATA_BYTES=8 for identical results.
